// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
//   loader_state_t : loader FSM state encoding
//   instr_word_t   : 32-bit instruction word, shared with the instruction memory
//   LEN_BYTES      : number of length-header bytes (little-endian)
//   BYTES_PER_WORD : stream bytes per instruction word
package instr_loader_pkg;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  typedef logic [31:0] instr_word_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6,
    S_CHECK  = 3'd7
  } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs little-endian stream bytes into 32-bit instruction words.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clear      : restart assembly at byte 0 (new load)
//   shift_en   : a byte is transferred this cycle
//   byte_in    : the transferred byte
//   word       : assembled word (first byte in [7:0], fourth in [31:24])
//   word_full  : the byte shifted in this cycle completes the word
module word_assembler
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output instr_word_t word,
  output logic        word_full
);

  logic [1:0] byte_cnt;

  assign word_full = shift_en && (byte_cnt == 2'(BYTES_PER_WORD - 1));

  // Shifting in from the top leaves the first byte in [7:0] after four shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (shift_en) begin
      word     <= {byte_in, word[31:8]};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a program image from a byte source into the instruction memory.
// Stream format: 16-bit little-endian word count, then 4 little-endian bytes
// per word. Words are written at consecutive word addresses from 0.
// Optional build macro LOADER_CHECKSUM_EN: one trailing byte must equal the
// XOR of all data bytes (header excluded), otherwise the load ends in error.
// Ports:
//   clk, rst_n             : clock, async active-low reset
//   start                  : begin a load (honoured in IDLE/DONE/ERR only)
//   byte_valid/byte_data   : byte source; transfer = byte_valid & byte_ready
//   byte_ready             : loader accepts a byte this cycle
//   mem_we/mem_addr/mem_wdata : instruction memory write port (word index)
//   busy, done, error      : status; done/error held until the next start
//   word_count             : words written in the current load
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | after reset, waiting for start
// S_LEN_LO | accept length byte [7:0]
// S_LEN_HI | accept length byte [15:8], route to DONE/ERR/DATA
// S_DATA   | accept data bytes into the word assembler
// S_WRITE  | one-cycle memory write of the assembled word
// S_CHECK  | accept and compare the checksum byte (checksum build only)
// S_DONE   | load completed, done=1
// S_ERR    | load aborted, error=1
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output instr_word_t       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  loader_state_t state, state_nxt;
  logic [15:0]   len;
  logic          start_load;
  logic          shift_en;
  logic          word_full;
  logic [16:0]   len_full;
  logic [16:0]   count_inc;
  logic          last_word;

  // Length candidate while the high byte is on the bus.
  assign len_full  = {1'b0, byte_data, len[7:0]};
  assign count_inc = 17'(word_count) + 17'd1;
  assign last_word = (count_inc == {1'b0, len});
  assign shift_en  = (state == S_DATA) && byte_valid;

  assign done  = (state == S_DONE);
  assign error = (state == S_ERR);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (start_load) begin
      csum <= '0;
    end else if (shift_en) begin
      csum <= csum ^ byte_data;
    end
  end
`endif

  word_assembler u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_load),
    .shift_en (shift_en),
    .byte_in  (byte_data),
    .word     (mem_wdata),
    .word_full(word_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    start_load = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          start_load = 1'b1;
          state_nxt  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          if (len_full == 17'd0)             state_nxt = S_DONE;
          else if (len_full > 17'(DEPTH))    state_nxt = S_ERR;
          else                               state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (word_full) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        state_nxt = last_word ? S_CHECK : S_DATA;
`else
        state_nxt = last_word ? S_DONE : S_DATA;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_nxt = (byte_data == csum) ? S_DONE : S_ERR;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len <= '0;
    end else if (byte_valid && state == S_LEN_LO) begin
      len[7:0] <= byte_data;
    end else if (byte_valid && state == S_LEN_HI) begin
      len[15:8] <= byte_data;
    end
  end

  // Address holds at DEPTH-1 after the final write instead of wrapping to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
      mem_addr   <= '0;
    end else if (start_load) begin
      word_count <= '0;
      mem_addr   <= '0;
    end else if (state == S_WRITE) begin
      word_count <= word_count + (ADDR_W+1)'(1);
      if (mem_addr != ADDR_W'(DEPTH - 1)) mem_addr <= mem_addr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader.
module tb_instr_mem_loader;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  typedef logic [7:0] byte_q_t[$];

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  int errors = 0;
  int checks = 0;

  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          ready_bad = 0;

  instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(mem_wdata);
      if (byte_ready) ready_bad++;
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    ready_bad = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: byte_ready=%b required 1 (byte %h)", byte_ready, b);
      byte_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 byte_valid = 1'b0;
    end
  endtask

  task automatic send_stream(input byte_q_t s, input int maxgap);
    foreach (s[i]) send_byte(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  // Header + data; the checksum build appends the XOR of the data bytes.
  task automatic load(input byte_q_t s, input int maxgap);
    byte_q_t    t;
    logic [7:0] x;
    t = s;
    x = 8'h00;
    for (int i = 2; i < s.size(); i++) x = x ^ s[i];
`ifdef LOADER_CHECKSUM_EN
    t.push_back(x);
`endif
    send_stream(t, maxgap);
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready: got %b want 0", byte_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", {busy, done, error}); end
    checks++; if (mem_addr !== '0 || mem_wdata !== 32'h0 || word_count !== '0) begin
      errors++; $display("FAIL reset_regs: addr=%0d wdata=%h count=%0d want 0", mem_addr, mem_wdata, word_count);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || byte_ready !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b ready=%b want 0 0", busy, byte_ready); end
  endtask

  task automatic test_two_words();
    byte_q_t     s;
    bit          ok;
    logic [31:0] exp_d[2];
    logic [31:0] got;
    exp_d = '{32'h00000013, 32'h00100093};
    clear_log();
    pulse_start();
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    load(s, 0);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL two_words_timeout: busy=%b want 0", busy); end
    checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL two_words_nwrites: got %0d want 2", wr_addr.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < wr_data.size()) ? wr_data[i] : 32'hxxxxxxxx;
      checks++; if (got !== exp_d[i] || (i < wr_addr.size() && wr_addr[i] != i)) begin
        errors++; $display("FAIL two_words_write%0d: data=%h want %h", i, got, exp_d[i]);
      end
    end
    checks++; if ({done, error} !== 2'b10 || word_count !== 11'd2) begin
      errors++; $display("FAIL two_words_status: done=%b error=%b count=%0d want 1 0 2", done, error, word_count);
    end
  endtask

  task automatic test_zero_len();
    byte_q_t s;
    bit      ok;
    clear_log();
    pulse_start();
    checks++; if (done !== 1'b0 || busy !== 1'b1 || word_count !== '0) begin
      errors++; $display("FAIL start_clears: done=%b busy=%b count=%0d want 0 1 0", done, busy, word_count);
    end
    s = '{8'h00, 8'h00};
    send_stream(s, 0);
    wait_idle(ok);
    checks++; if (!ok || {done, error} !== 2'b10) begin errors++; $display("FAIL zero_len_status: done=%b error=%b want 1 0", done, error); end
    checks++; if (wr_addr.size() != 0 || word_count !== '0) begin
      errors++; $display("FAIL zero_len_writes: nwrites=%0d count=%0d want 0 0", wr_addr.size(), word_count);
    end
  endtask

  task automatic test_too_long();
    byte_q_t s;
    int      rdy;
    clear_log();
    pulse_start();
    s = '{8'h01, 8'h04};
    send_stream(s, 0);
    @(negedge clk);
    checks++; if ({done, error, busy} !== 3'b010) begin
      errors++; $display("FAIL too_long_status: done=%b error=%b busy=%b want 0 1 0", done, error, busy);
    end
    byte_valid = 1'b1;
    byte_data  = 8'h5a;
    rdy = 0;
    repeat (5) begin
      @(negedge clk);
      if (byte_ready) rdy++;
    end
    byte_valid = 1'b0;
    checks++; if (rdy != 0 || wr_addr.size() != 0 || error !== 1'b1) begin
      errors++; $display("FAIL too_long_blocked: ready_cycles=%0d nwrites=%0d error=%b want 0 0 1", rdy, wr_addr.size(), error);
    end
  endtask

  task automatic test_gaps();
    byte_q_t     s;
    bit          ok;
    logic [31:0] exp_d[3];
    logic [31:0] got;
    exp_d = '{32'h04030201, 32'h08070605, 32'h0c0b0a09};
    s = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
          8'h07, 8'h08, 8'h09, 8'h0a, 8'h0b, 8'h0c};
    for (int run = 0; run < 2; run++) begin
      clear_log();
      pulse_start();
      load(s, (run == 0) ? 0 : 3);
      wait_idle(ok);
      checks++; if (!ok || wr_addr.size() != 3) begin
        errors++; $display("FAIL gaps%0d_nwrites: got %0d want 3", run, wr_addr.size());
      end
      for (int i = 0; i < 3; i++) begin
        got = (i < wr_data.size()) ? wr_data[i] : 32'hxxxxxxxx;
        checks++; if (got !== exp_d[i] || (i < wr_addr.size() && wr_addr[i] != i)) begin
          errors++; $display("FAIL gaps%0d_write%0d: data=%h want %h", run, i, got, exp_d[i]);
        end
      end
      checks++; if (ready_bad != 0) begin errors++; $display("FAIL gaps%0d_ready_in_write: got %0d want 0", run, ready_bad); end
      checks++; if (done !== 1'b1 || word_count !== 11'd3) begin
        errors++; $display("FAIL gaps%0d_status: done=%b count=%0d want 1 3", run, done, word_count);
      end
    end
  endtask

  task automatic test_reset_midload();
    byte_q_t s;
    bit      ok;
    logic [31:0] got;
    clear_log();
    pulse_start();
    s = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_stream(s, 0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++; if ({byte_ready, mem_we, busy, done, error} !== 5'b0 || mem_addr !== '0 ||
                  mem_wdata !== 32'h0 || word_count !== '0) begin
      errors++; $display("FAIL midload_reset: ready=%b we=%b busy=%b done=%b err=%b addr=%0d wdata=%h count=%0d want all 0",
                         byte_ready, mem_we, busy, done, error, mem_addr, mem_wdata, word_count);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checks++; if (wr_addr.size() != 1) begin errors++; $display("FAIL midload_partial_writes: got %0d want 1", wr_addr.size()); end
    clear_log();
    pulse_start();
    s = '{8'h01, 8'h00, 8'haa, 8'hbb, 8'hcc, 8'hdd};
    load(s, 0);
    wait_idle(ok);
    got = (wr_data.size() > 0) ? wr_data[0] : 32'hxxxxxxxx;
    checks++; if (!ok || wr_addr.size() != 1 || got !== 32'hddccbbaa || wr_addr[0] != 0) begin
      errors++; $display("FAIL after_reset_load: nwrites=%0d data=%h want 1 ddccbbaa", wr_addr.size(), got);
    end
    checks++; if (done !== 1'b1 || word_count !== 11'd1) begin
      errors++; $display("FAIL after_reset_status: done=%b count=%0d want 1 1", done, word_count);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    byte_q_t s;
    bit      ok;
    logic [31:0] got;
    clear_log();
    pulse_start();
    s = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_stream(s, 0);
    wait_idle(ok);
    checks++; if (!ok || {done, error} !== 2'b10) begin errors++; $display("FAIL csum_good: done=%b error=%b want 1 0", done, error); end
    clear_log();
    pulse_start();
    s = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    send_stream(s, 0);
    wait_idle(ok);
    checks++; if (!ok || {done, error} !== 2'b01) begin errors++; $display("FAIL csum_bad: done=%b error=%b want 0 1", done, error); end
    got = (wr_data.size() > 0) ? wr_data[0] : 32'hxxxxxxxx;
    checks++; if (wr_addr.size() != 1 || got !== 32'h44332211 || wr_addr[0] != 0) begin
      errors++; $display("FAIL csum_bad_write: nwrites=%0d data=%h want 1 44332211", wr_addr.size(), got);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_zero_len();
    test_too_long();
    test_gaps();
    test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
